// File: rtl/bb_pkg.sv
// Shared encodings for the BitBlaster sequencer.
// Opcodes, instruction classes and timestep states.
package bb_pkg;

    localparam logic [3:0] LOAD = 4'b0000;
    localparam logic [3:0] COPY = 4'b0001;
    localparam logic [3:0] ADD  = 4'b0010;
    localparam logic [3:0] SUB  = 4'b0011;
    localparam logic [3:0] INV  = 4'b0100;
    localparam logic [3:0] FLP  = 4'b0101;
    localparam logic [3:0] AND  = 4'b0110;
    localparam logic [3:0] OR   = 4'b0111;
    localparam logic [3:0] XOR  = 4'b1000;
    localparam logic [3:0] LSL  = 4'b1001;
    localparam logic [3:0] LSR  = 4'b1010;
    localparam logic [3:0] ASR  = 4'b1011;

    localparam logic [3:0] ADDI_ALU = 4'b0010;
    localparam logic [3:0] SUBI_ALU = 4'b0011;

    localparam logic [1:0] CLS_REG  = 2'b00;
    localparam logic [1:0] CLS_ADDI = 2'b10;
    localparam logic [1:0] CLS_SUBI = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        T1   = 2'd1,
        T2   = 2'd2,
        T3   = 2'd3
    } tstep_t;

endpackage

// File: rtl/bb_tstep_counter.sv
// Timestep register for the sequencer; BB_SEQ_SINGLE_STEP_EN
// adds a step gate that stalls T1..T3 until step is high.
module bb_tstep_counter
    import bb_pkg::*;
(
    input  logic   clk,
    input  logic   rst_n,
`ifdef BB_SEQ_SINGLE_STEP_EN
    input  logic   step,
`endif
    input  logic   advance,
    input  logic   clear,
    output tstep_t state
);

    logic gate;

`ifdef BB_SEQ_SINGLE_STEP_EN
    assign gate = (state == IDLE) || step;
`else
    assign gate = 1'b1;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else if (gate) begin
            if (clear)
                state <= IDLE;
            else if (advance)
                state <= tstep_t'(state + 2'd1);
        end
    end

endmodule

// File: rtl/bb_sequencer.sv
// BitBlaster multi-cycle control sequencer with start/done handshake.
// Optional single-step mode under BB_SEQ_SINGLE_STEP_EN.
module bb_sequencer
    import bb_pkg::*;
#(
    parameter int DATA_W = 10,
    parameter int REG_AW = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              exec,
`ifdef BB_SEQ_SINGLE_STEP_EN
    input  logic              step,
`endif
    input  logic [DATA_W-1:0] data_in,
    output logic [DATA_W-1:0] imm,
    output logic              imm_oe,
    output logic [REG_AW-1:0] rin,
    output logic [REG_AW-1:0] rout,
    output logic              enw,
    output logic              enr,
    output logic              ain,
    output logic              gin,
    output logic              gout,
    output logic [3:0]        alu_cont,
    output logic              ext,
    output logic              irin,
    output logic              busy,
    output logic              done,
    output logic              illegal
);

    localparam int IMM_W = DATA_W - 2 - REG_AW;

    generate
        if (DATA_W != 2 + 2 * REG_AW + 4) begin : g_bad_width
            $error("bb_sequencer: DATA_W must equal 2+2*REG_AW+4");
        end
    endgenerate

    tstep_t            state;
    logic              advance;
    logic              clear;
    logic              live;
    logic [DATA_W-1:0] ir;

    logic [1:0]        cls;
    logic [REG_AW-1:0] rx;
    logic [REG_AW-1:0] ry;
    logic [3:0]        op;
    logic              reg_cls;
    logic              is_ld;
    logic              is_cp;
    logic              is_rop;
    logic              is_iop;

    bb_tstep_counter u_tstep (
        .clk     (clk),
        .rst_n   (rst_n),
`ifdef BB_SEQ_SINGLE_STEP_EN
        .step    (step),
`endif
        .advance (advance),
        .clear   (clear),
        .state   (state)
    );

`ifdef BB_SEQ_SINGLE_STEP_EN
    assign live = (state == IDLE) || step;
`else
    assign live = 1'b1;
`endif

    assign cls     = ir[DATA_W-1 -: 2];
    assign rx      = ir[DATA_W-3 -: REG_AW];
    assign ry      = ir[DATA_W-3-REG_AW -: REG_AW];
    assign op      = ir[3:0];
    assign reg_cls = (cls == CLS_REG);
    assign is_ld   = reg_cls && (op == LOAD);
    assign is_cp   = reg_cls && (op == COPY);
    assign is_rop  = reg_cls && (op >= ADD) && (op <= ASR);
    assign is_iop  = (cls == CLS_ADDI) || (cls == CLS_SUBI);

    assign busy = (state != IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            ir <= '0;
        else if (irin)
            ir <= data_in;
    end

    // rst_n gates the outputs so a fetch request cannot leak out during reset
    always_comb begin
        imm      = '0;
        imm_oe   = 1'b0;
        rin      = '0;
        rout     = '0;
        enw      = 1'b0;
        enr      = 1'b0;
        ain      = 1'b0;
        gin      = 1'b0;
        gout     = 1'b0;
        alu_cont = '0;
        ext      = 1'b0;
        irin     = 1'b0;
        done     = 1'b0;
        illegal  = 1'b0;
        advance  = 1'b0;
        clear    = 1'b0;
        if (rst_n && live) begin
            unique case (state)
                IDLE: begin
                    if (exec) begin
                        ext     = 1'b1;
                        irin    = 1'b1;
                        advance = 1'b1;
                    end
                end
                T1: begin
                    unique case (1'b1)
                        is_ld: begin
                            ext   = 1'b1;
                            rin   = rx;
                            enr   = 1'b1;
                            done  = 1'b1;
                            clear = 1'b1;
                        end
                        is_cp: begin
                            rout  = ry;
                            enw   = 1'b1;
                            rin   = rx;
                            enr   = 1'b1;
                            done  = 1'b1;
                            clear = 1'b1;
                        end
                        is_rop, is_iop: begin
                            rout    = rx;
                            enw     = 1'b1;
                            ain     = 1'b1;
                            advance = 1'b1;
                        end
                        default: begin
                            illegal = 1'b1;
                            clear   = 1'b1;
                        end
                    endcase
                end
                T2: begin
                    gin     = 1'b1;
                    advance = 1'b1;
                    if (is_iop) begin
                        imm_oe   = 1'b1;
                        imm      = {{(DATA_W-IMM_W){1'b0}}, ir[IMM_W-1:0]};
                        alu_cont = (cls == CLS_ADDI) ? ADDI_ALU : SUBI_ALU;
                    end else begin
                        rout     = ry;
                        enw      = 1'b1;
                        alu_cont = op;
                    end
                end
                T3: begin
                    gout  = 1'b1;
                    rin   = rx;
                    enr   = 1'b1;
                    done  = 1'b1;
                    clear = 1'b1;
                end
                default: clear = 1'b1;
            endcase
        end
    end

endmodule

// File: tb/tb_bb_sequencer.sv
// Directed vector bench for bb_sequencer.
// Covers single-step mode when BB_SEQ_SINGLE_STEP_EN is defined.
module tb_bb_sequencer;

    typedef struct packed {
        logic       imm_oe;
        logic [9:0] imm;
        logic [1:0] rin;
        logic [1:0] rout;
        logic       enw;
        logic       enr;
        logic       ain;
        logic       gin;
        logic       gout;
        logic [3:0] alu;
        logic       ext;
        logic       irin;
        logic       busy;
        logic       done;
        logic       illegal;
    } obs_t;

    typedef struct {
        string          name;
        logic [9:0]     instr;
        int             len;
        obs_t [3:0]     exp;
    } vec_t;

    logic       clk;
    logic       rst_n;
    logic       exec;
    logic       step;
    logic [9:0] data_in;
    logic [9:0] imm;
    logic       imm_oe;
    logic [1:0] rin;
    logic [1:0] rout;
    logic       enw;
    logic       enr;
    logic       ain;
    logic       gin;
    logic       gout;
    logic [3:0] alu_cont;
    logic       ext;
    logic       irin;
    logic       busy;
    logic       done;
    logic       illegal;

    int errors = 0;
    int checks = 0;

    bb_sequencer #(.DATA_W(10), .REG_AW(2)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .exec     (exec),
`ifdef BB_SEQ_SINGLE_STEP_EN
        .step     (step),
`endif
        .data_in  (data_in),
        .imm      (imm),
        .imm_oe   (imm_oe),
        .rin      (rin),
        .rout     (rout),
        .enw      (enw),
        .enr      (enr),
        .ain      (ain),
        .gin      (gin),
        .gout     (gout),
        .alu_cont (alu_cont),
        .ext      (ext),
        .irin     (irin),
        .busy     (busy),
        .done     (done),
        .illegal  (illegal)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // en = {enw,enr,ain,gin,gout}; fl = {ext,irin,busy,done,illegal}
    function automatic obs_t o(input logic ioe, input logic [9:0] im,
                               input logic [1:0] ri, input logic [1:0] ro,
                               input logic [4:0] en, input logic [3:0] alu,
                               input logic [4:0] fl);
        obs_t r;
        r = {ioe, im, ri, ro, en, alu, fl};
        return r;
    endfunction

    function automatic obs_t cur();
        obs_t r;
        r = {imm_oe, imm, rin, rout, enw, enr, ain, gin, gout, alu_cont,
             ext, irin, busy, done, illegal};
        return r;
    endfunction

    task automatic check(input string name, input obs_t exp);
        obs_t act;
        act = cur();
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic cyc(input logic ex, input logic [9:0] d);
        @(negedge clk);
        exec    = ex;
        data_in = d;
        #1;
    endtask

    always @(posedge clk) begin
        if (rst_n) begin
            assert (int'(ext) + int'(enw) + int'(gout) + int'(imm_oe) <= 1)
            else begin
                errors++;
                $display("FAIL bus_excl: ext=%b enw=%b gout=%b imm_oe=%b",
                         ext, enw, gout, imm_oe);
            end
            assert (imm_oe || imm == 10'd0)
            else begin
                errors++;
                $display("FAIL imm_zero: imm=%h imm_oe=0", imm);
            end
        end
    end

    obs_t fetch;
    obs_t idle;
    obs_t stall;
    obs_t add_exp [4];
    vec_t vec [9];

    initial begin
        fetch = o(0, 0, 0, 0, 5'b00000, 0, 5'b11000);
        idle  = '0;
        stall = o(0, 0, 0, 0, 5'b00000, 0, 5'b00100);
        add_exp[0] = fetch;
        add_exp[1] = o(0, 0, 0, 1, 5'b10100, 4'h0, 5'b00100);
        add_exp[2] = o(0, 0, 0, 3, 5'b10010, 4'h2, 5'b00100);
        add_exp[3] = o(0, 0, 1, 0, 5'b01001, 4'h0, 5'b00110);

        vec[0] = '{"load", 10'h080, 2, '{idle, idle,
                   o(0, 0, 2, 0, 5'b01000, 0, 5'b10110), fetch}};
        vec[1] = '{"add", 10'h072, 4, '{add_exp[3], add_exp[2],
                   add_exp[1], fetch}};
        vec[2] = '{"subi", 10'h3AD, 4, '{
                   o(0, 0, 2, 0, 5'b01001, 0, 5'b00110),
                   o(1, 10'h02D, 0, 0, 5'b00010, 4'h3, 5'b00100),
                   o(0, 0, 0, 2, 5'b10100, 0, 5'b00100), fetch}};
        vec[3] = '{"ill_cls01", 10'h100, 2, '{idle, idle,
                   o(0, 0, 0, 0, 5'b00000, 0, 5'b00101), fetch}};
        vec[4] = '{"ill_op1110", 10'h00E, 2, '{idle, idle,
                   o(0, 0, 0, 0, 5'b00000, 0, 5'b00101), fetch}};
        vec[5] = '{"copy", 10'h0C1, 2, '{idle, idle,
                   o(0, 0, 3, 0, 5'b11000, 0, 5'b00110), fetch}};
        vec[6] = '{"addi", 10'h23F, 4, '{
                   o(0, 0, 0, 0, 5'b01001, 0, 5'b00110),
                   o(1, 10'h03F, 0, 0, 5'b00010, 4'h2, 5'b00100),
                   o(0, 0, 0, 0, 5'b10100, 0, 5'b00100), fetch}};
        vec[7] = '{"asr", 10'h09B, 4, '{
                   o(0, 0, 2, 0, 5'b01001, 0, 5'b00110),
                   o(0, 0, 0, 1, 5'b10010, 4'hB, 5'b00100),
                   o(0, 0, 0, 2, 5'b10100, 0, 5'b00100), fetch}};
        vec[8] = '{"ill_op1100", 10'h06C, 2, '{idle, idle,
                   o(0, 0, 0, 0, 5'b00000, 0, 5'b00101), fetch}};

        rst_n   = 1'b0;
        exec    = 1'b1;
        step    = 1'b1;
        data_in = 10'h072;
        #12;
        check("reset", idle);
        @(negedge clk);
        exec  = 1'b0;
        rst_n = 1'b1;
        #1;
        check("idle_after_reset", idle);

        for (int v = 0; v < 9; v++) begin
            for (int c = 0; c < vec[v].len; c++) begin
                cyc(c == 0, c == 0 ? vec[v].instr : 10'h155);
                check($sformatf("%s_c%0d", vec[v].name, c), vec[v].exp[c]);
            end
            cyc(1'b0, 10'h000);
            check($sformatf("%s_idle", vec[v].name), idle);
        end

        // exec during busy is ignored; held exec refetches after done
        cyc(1'b1, 10'h072);
        check("busy_c0", fetch);
        for (int c = 1; c < 4; c++) begin
            cyc(1'b1, 10'h100);
            check($sformatf("busy_c%0d", c), add_exp[c]);
        end
        cyc(1'b1, 10'h080);
        check("b2b_fetch", fetch);
        cyc(1'b0, 10'h155);
        check("b2b_load", o(0, 0, 2, 0, 5'b01000, 0, 5'b10110));
        cyc(1'b0, 10'h000);
        check("b2b_idle", idle);

        // reset during T2 of XOR R1,R2
        cyc(1'b1, 10'h068);
        cyc(1'b0, 10'h000);
        cyc(1'b0, 10'h000);
        check("xor_t2", o(0, 0, 0, 2, 5'b10010, 4'h8, 5'b00100));
        #2;
        rst_n = 1'b0;
        #1;
        check("abort_async", idle);
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 4; c++) begin
            cyc(1'b0, 10'h000);
            check($sformatf("abort_after_%0d", c), idle);
        end

`ifdef BB_SEQ_SINGLE_STEP_EN
        step = 1'b0;
        cyc(1'b1, 10'h072);
        check("step_fetch", fetch);
        for (int k = 1; k < 4; k++) begin
            for (int s = 0; s < 2; s++) begin
                step = 1'b0;
                cyc(1'b0, 10'h155);
                check($sformatf("step_stall_%0d_%0d", k, s), stall);
            end
            step = 1'b1;
            cyc(1'b0, 10'h155);
            check($sformatf("step_t%0d", k), add_exp[k]);
        end
        step = 1'b0;
        cyc(1'b0, 10'h000);
        check("step_idle", idle);
        step = 1'b1;
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
